// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory with a registered read.
// Round-robin fairness, plus a bounded burst lock for the peripheral port.
module mem_port_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [WIDTH-1:0]  c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [WIDTH-1:0]  c_rdata,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [WIDTH-1:0]  p_wdata,
    input  logic              p_lock,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [WIDTH-1:0]  p_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [WIDTH-1:0]  m_wdata,
    input  logic [WIDTH-1:0]  m_rdata,
    output logic              busy,
    output logic              owner
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, ACC, RD} state_t;

    state_t            state_q;
    logic              win_q;
    logic              we_q;
    logic              owner_q;
    logic [BW-1:0]     burst_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic              m_we_q;
    logic [WIDTH-1:0]  m_wdata_q;
    logic              c_gnt_q;
    logic              p_gnt_q;
    logic              c_rv_q;
    logic              p_rv_q;
    logic [WIDTH-1:0]  c_rdata_q;
    logic [WIDTH-1:0]  p_rdata_q;

    logic              win_d;
    logic [BW-1:0]     burst_d;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_wdata;

    // win_d: 0 = core, 1 = peripheral
    always_comb begin
        win_d = p_req;
        if (c_req && p_req) begin
            if (p_lock) begin
                win_d = (burst_q < BMAX);
            end else begin
                win_d = ~owner_q;
            end
        end
    end

    always_comb begin
        burst_d = burst_q;
        if (state_q == IDLE) begin
            if (!p_lock) begin
                burst_d = '0;
            end
            if (c_req || p_req) begin
                if (!win_d) begin
                    burst_d = '0;
                end else if (p_lock && c_req && burst_q != BMAX) begin
                    burst_d = burst_q + 1'b1;
                end
            end
        end
    end

    assign sel_we    = win_d ? p_we    : c_we;
    assign sel_addr  = win_d ? p_addr  : c_addr;
    assign sel_wdata = win_d ? p_wdata : c_wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            owner_q   <= 1'b1;
            burst_q   <= '0;
            m_addr_q  <= '0;
            m_we_q    <= 1'b0;
            m_wdata_q <= '0;
            c_gnt_q   <= 1'b0;
            p_gnt_q   <= 1'b0;
            c_rv_q    <= 1'b0;
            p_rv_q    <= 1'b0;
            c_rdata_q <= '0;
            p_rdata_q <= '0;
        end else begin
            c_gnt_q <= 1'b0;
            p_gnt_q <= 1'b0;
            c_rv_q  <= 1'b0;
            p_rv_q  <= 1'b0;
            m_we_q  <= 1'b0;
            burst_q <= burst_d;
            unique case (state_q)
                IDLE: begin
                    if (c_req || p_req) begin
                        state_q   <= ACC;
                        win_q     <= win_d;
                        owner_q   <= win_d;
                        we_q      <= sel_we;
                        m_we_q    <= sel_we;
                        m_addr_q  <= sel_addr;
                        m_wdata_q <= sel_wdata;
                        c_gnt_q   <= ~win_d;
                        p_gnt_q   <= win_d;
                    end
                end
                ACC: begin
                    if (we_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= RD;
                        c_rv_q  <= ~win_q;
                        p_rv_q  <= win_q;
                    end
                end
                RD: begin
                    state_q <= IDLE;
                    if (win_q) begin
                        p_rdata_q <= m_rdata;
                    end else begin
                        c_rdata_q <= m_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data passes straight through in RD, then is held from the capture.
    assign c_rdata  = (state_q == RD && !win_q) ? m_rdata : c_rdata_q;
    assign p_rdata  = (state_q == RD &&  win_q) ? m_rdata : p_rdata_q;
    assign c_gnt    = c_gnt_q;
    assign p_gnt    = p_gnt_q;
    assign c_rvalid = c_rv_q;
    assign p_rvalid = p_rv_q;
    assign m_addr   = m_addr_q;
    assign m_we     = m_we_q;
    assign m_wdata  = m_wdata_q;
    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int W  = 32;
    localparam int A  = 8;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         c_req = 1'b0, c_we = 1'b0;
    logic [A-1:0] c_addr = '0;
    logic [W-1:0] c_wdata = '0;
    logic         p_req = 1'b0, p_we = 1'b0, p_lock = 1'b0;
    logic [A-1:0] p_addr = '0;
    logic [W-1:0] p_wdata = '0;
    logic         c_gnt, c_rvalid, p_gnt, p_rvalid;
    logic [W-1:0] c_rdata, p_rdata;
    logic [A-1:0] m_addr;
    logic         m_we;
    logic [W-1:0] m_wdata;
    logic [W-1:0] m_rdata;
    logic         busy, owner;

    mem_port_arbiter #(.WIDTH(W), .ADDR_W(A), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_lock(p_lock), .p_gnt(p_gnt), .p_rvalid(p_rvalid),
        .p_rdata(p_rdata),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] seed(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return 32'h5A000000 ^ (32'(i) * 32'h00010203);
    endfunction

    // Memory with registered read; contents reload while reset is held.
    logic [W-1:0] ram [256];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed(i);
        end else if (m_we) begin
            ram[m_addr] <= m_wdata;
        end
        m_rdata <= ram[m_addr];
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference model: one transaction at a time, counted in busy cycles.
    logic [W-1:0] mref [256];
    int           md_left  = 0;
    int           md_burst = 0;
    bit           md_owner = 1'b1;
    bit           md_who, md_we;
    logic [A-1:0] md_addr;
    logic         e_cg, e_pg, e_cr, e_pr, e_mwe, e_busy;
    logic [A-1:0] e_ma;
    logic [W-1:0] e_md, e_crd, e_prd;

    bit gseq[$];
    int cnt_pg, cnt_mwe, cnt_prv, cnt_crv;

    task automatic tick();
        logic r, cq, cw, pq, pw, pl, who;
        logic [A-1:0] ca, pa;
        logic [W-1:0] cd, pd, wd;
        r = rst; cq = c_req; cw = c_we; ca = c_addr; cd = c_wdata;
        pq = p_req; pw = p_we; pa = p_addr; pd = p_wdata; pl = p_lock;
        @(posedge clk);
        if (!r) begin
            md_left = 0; md_burst = 0; md_owner = 1'b1;
            {e_cg, e_pg, e_cr, e_pr, e_mwe, e_busy} = '0;
            e_ma = '0; e_md = '0; e_crd = '0; e_prd = '0;
            for (int i = 0; i < 256; i++) mref[i] = seed(i);
        end else begin
            {e_cg, e_pg, e_cr, e_pr, e_mwe} = '0;
            if (md_left == 0) begin
                if (!pl) md_burst = 0;
                if (cq || pq) begin
                    if (cq && pq) who = pl ? (md_burst < MB) : !md_owner;
                    else who = pq;
                    if (!who) md_burst = 0;
                    else if (pl && cq)
                        md_burst = (md_burst + 1 > MB) ? MB : md_burst + 1;
                    md_owner = who; md_who = who;
                    md_we = who ? pw : cw;
                    md_addr = who ? pa : ca;
                    wd = who ? pd : cd;
                    e_cg = !who; e_pg = who; e_mwe = md_we;
                    e_ma = md_addr; e_md = wd;
                    if (md_we) mref[md_addr] = wd;
                    md_left = md_we ? 1 : 2;
                end
            end else begin
                md_left--;
                if (md_left == 1) begin
                    if (md_who) begin e_pr = 1; e_prd = mref[md_addr]; end
                    else begin e_cr = 1; e_crd = mref[md_addr]; end
                end
            end
            e_busy = (md_left != 0);
        end
        #1;
        chk("c_gnt", 64'(c_gnt), 64'(e_cg));
        chk("p_gnt", 64'(p_gnt), 64'(e_pg));
        chk("c_rvalid", 64'(c_rvalid), 64'(e_cr));
        chk("p_rvalid", 64'(p_rvalid), 64'(e_pr));
        chk("m_we", 64'(m_we), 64'(e_mwe));
        chk("m_addr", 64'(m_addr), 64'(e_ma));
        chk("m_wdata", 64'(m_wdata), 64'(e_md));
        chk("c_rdata", 64'(c_rdata), 64'(e_crd));
        chk("p_rdata", 64'(p_rdata), 64'(e_prd));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("owner", 64'(owner), 64'(md_owner));
        if (c_gnt) gseq.push_back(1'b0);
        if (p_gnt) gseq.push_back(1'b1);
        cnt_pg  += int'(p_gnt);
        cnt_mwe += int'(m_we);
        cnt_prv += int'(p_rvalid);
        cnt_crv += int'(c_rvalid);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        c_req = 1'b0; p_req = 1'b0; p_lock = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    bit c_pend, p_pend;

    task automatic drive_rand();
        if (c_gnt) c_pend = 1'b0;
        if (p_gnt) p_pend = 1'b0;
        if (!c_pend && $urandom_range(0, 2) == 0) begin
            c_pend = 1'b1; c_we = 1'($urandom_range(0, 1));
            c_addr = 8'($urandom_range(0, 15)); c_wdata = $urandom;
        end
        if (!p_pend && $urandom_range(0, 2) == 0) begin
            p_pend = 1'b1; p_we = 1'($urandom_range(0, 1));
            p_addr = 8'($urandom_range(0, 15)); p_wdata = $urandom;
        end
        p_lock = ($urandom_range(0, 3) != 0);
        c_req = c_pend;
        p_req = p_pend;
    endtask

    initial begin
        // Reset state, then a core read of 0x10 on the first IDLE sample
        repeat (3) tick();
        rst = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
        tick();
        chk("r031_gnt", 64'(c_gnt), 64'd1);
        c_req = 1'b0;
        tick();
        chk("r031_rvalid", 64'(c_rvalid), 64'd1);
        chk("r031_rdata", 64'(c_rdata), 64'hDEADBEEF);
        tick();

        // Simultaneous writes: core, peripheral, core
        do_reset();
        gseq.delete();
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h01; c_wdata = 32'h11111111;
        p_req = 1'b1; p_we = 1'b1; p_addr = 8'h02; p_wdata = 32'h22222222;
        cnt_mwe = 0;
        repeat (6) tick();
        chk("r032_count", 64'(gseq.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            chk("r032_order", 64'(gseq[i]), 64'(i % 2));
        chk("r032_mwe", 64'(cnt_mwe), 64'd3);

        // Locked burst: four peripheral grants per core grant
        do_reset();
        gseq.delete();
        c_req = 1'b1; p_req = 1'b1; p_lock = 1'b1;
        repeat (40) tick();
        chk("r033_count", 64'(gseq.size()), 64'd20);
        for (int i = 0; i < 20; i++)
            chk("r033_pattern", 64'(gseq[i]), 64'(i % 5 != 4));

        // Reset during ACC of a peripheral read
        do_reset();
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'h20;
        tick();
        chk("r034_gnt", 64'(p_gnt), 64'd1);
        rst = 1'b0; p_req = 1'b0;
        cnt_prv = 0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("r034_no_rvalid", 64'(cnt_prv), 64'd0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
        cnt_crv = 0;
        tick();
        c_req = 1'b0;
        repeat (2) tick();
        chk("r034_after_rv", 64'(cnt_crv), 64'd1);
        chk("r034_after_rd", 64'(c_rdata), 64'hDEADBEEF);

        // Peripheral drops req right after the IDLE sample
        p_req = 1'b1; p_we = 1'b1; p_addr = 8'h30; p_wdata = 32'hCAFE0030;
        cnt_pg = 0; cnt_mwe = 0;
        tick();
        p_req = 1'b0;
        repeat (3) tick();
        chk("r035_gnt", 64'(cnt_pg), 64'd1);
        chk("r035_mwe", 64'(cnt_mwe), 64'd1);
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h30;
        tick();
        c_req = 1'b0;
        repeat (2) tick();
        chk("r035_data", 64'(c_rdata), 64'hCAFE0030);

        // Random traffic from both requesters
        c_pend = 1'b0; p_pend = 1'b0;
        for (int n = 0; n < 600; n++) begin
            drive_rand();
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
